// File: rtl/mux_pkg.sv
// Shared constants for the N-to-1 selector.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   clog2                : ceiling log2 for tools without $clog2
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority request search, purely combinational.
//   req          : per-channel requests
//   ptr          : last granted channel; search starts at ptr+1 and wraps
//   grant_onehot : one-hot grant (zero when nothing requests)
//   grant_idx    : index of the granted channel
//   any          : at least one request present
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 16,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx          = '0;
    // Offset 1..N from ptr; offset N lands on ptr itself, so the last
    // granted channel gets lowest priority but is still reachable.
    for (int k = 1; k <= N; k++) begin
      int i;
      i = int'(ptr) + k;
      if (i >= N) i -= N;
      idx = W'(i);
      if (!any && req[idx]) begin
        any               = 1'b1;
        grant_idx         = idx;
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter_n_to_1.sv
// N-to-1 datapath selector with registered output and valid/ready handshake.
//   clk, rst_n            : clock, async active-low reset
//   in_data / in_valid    : NUM_INPUTS channels, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready              : per-channel accept, one-hot or zero
//   mode                  : 0 fixed select via mult_select, 1 round-robin
//   out_data / out_valid  : held output word
//   out_ready             : downstream accept
//   out_source            : channel that supplied out_data
module mux_arbiter_n_to_1
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 16,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  input  logic                             mode,
  input  logic [SEL_WIDTH-1:0]             mult_select,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SEL_WIDTH-1:0]             out_source
);

  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] words;
  logic [SEL_WIDTH-1:0]  rr_ptr, rr_idx, g;
  logic [NUM_INPUTS-1:0] rr_oh;
  logic                  rr_any, g_ok, can_load, xfer;

  assign words = in_data;

  rr_arbiter #(.N(NUM_INPUTS), .W(SEL_WIDTH)) u_rr (
    .req          (in_valid),
    .ptr          (rr_ptr),
    .grant_onehot (rr_oh),
    .grant_idx    (rr_idx),
    .any          (rr_any)
  );

  // can_load uses only the registered out_valid, so out_ready reaches
  // in_ready without any path back from in_valid.
  always_comb begin
    can_load = !out_valid | out_ready;
    if (mode == MODE_RR) begin
      g    = rr_idx;
      g_ok = rr_any;
    end else begin
      g    = mult_select;
      g_ok = (int'(mult_select) < NUM_INPUTS);
    end
    in_ready = '0;
    if (rst_n && g_ok && can_load) begin
      if (mode == MODE_RR) in_ready = rr_oh;
      else                 in_ready[g] = 1'b1;
    end
    xfer = g_ok && in_ready[g] && in_valid[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_source <= '0;
      // Pointer at the top channel makes channel 0 first in line.
      rr_ptr     <= SEL_WIDTH'(NUM_INPUTS - 1);
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= words[g];
      out_source <= g;
      if (mode == MODE_RR) rr_ptr <= g;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter_n_to_1.sv
module tb_mux_arbiter_n_to_1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 16 x 32, DUT B: 5 x 8 (non power of two, reaches invalid selects)
  logic [16*32-1:0] a_data;
  logic [15:0]      a_valid, a_ready;
  logic             a_mode, a_oready, a_ovalid;
  logic [3:0]       a_sel, a_osrc;
  logic [31:0]      a_odata;

  logic [5*8-1:0]   b_data;
  logic [4:0]       b_valid, b_ready;
  logic             b_mode, b_oready, b_ovalid;
  logic [2:0]       b_sel, b_osrc;
  logic [7:0]       b_odata;

  mux_arbiter_n_to_1 #(.DATA_WIDTH(32), .NUM_INPUTS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .mode(a_mode), .mult_select(a_sel), .out_data(a_odata), .out_valid(a_ovalid),
    .out_ready(a_oready), .out_source(a_osrc));

  mux_arbiter_n_to_1 #(.DATA_WIDTH(8), .NUM_INPUTS(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .mode(b_mode), .mult_select(b_sel), .out_data(b_odata), .out_valid(b_ovalid),
    .out_ready(b_oready), .out_source(b_osrc));

  int chk_cnt = 0;
  int pass_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit          mv[2];
  logic [31:0] md[2];
  int          ms[2];
  int          mp[2];

  function automatic int f_n(input int d);        return d == 0 ? 16 : 5; endfunction
  function automatic logic [63:0] f_valid(input int d);
    return d == 0 ? 64'(a_valid) : 64'(b_valid);
  endfunction
  function automatic bit f_mode(input int d);     return d == 0 ? a_mode : b_mode; endfunction
  function automatic int f_sel(input int d);      return d == 0 ? int'(a_sel) : int'(b_sel); endfunction
  function automatic bit f_ordy(input int d);     return d == 0 ? a_oready : b_oready; endfunction
  function automatic logic [31:0] f_chan(input int d, input int g);
    return d == 0 ? a_data[g*32 +: 32] : 32'(b_data[g*8 +: 8]);
  endfunction

  // Granted channel under the selection rules, or -1 for none.
  function automatic int model_grant(input int d);
    int n;
    logic [63:0] v;
    n = f_n(d);
    v = f_valid(d);
    if (!f_mode(d)) return (f_sel(d) < n) ? f_sel(d) : -1;
    for (int k = 1; k <= n; k++)
      if (v[(mp[d] + k) % n]) return (mp[d] + k) % n;
    return -1;
  endfunction

  function automatic logic [63:0] exp_ready(input int d);
    int g;
    logic [63:0] r;
    r = '0;
    g = model_grant(d);
    if (g >= 0 && (!mv[d] || f_ordy(d))) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mv[d] = 1'b0; md[d] = '0; ms[d] = 0; mp[d] = f_n(d) - 1;
      end else begin
        int g;
        logic [63:0] v;
        g = model_grant(d);
        v = f_valid(d);
        if (g >= 0 && (!mv[d] || f_ordy(d)) && v[g]) begin
          mv[d] = 1'b1; md[d] = f_chan(d, g); ms[d] = g;
          if (f_mode(d)) mp[d] = g;
        end else if (mv[d] && f_ordy(d)) begin
          mv[d] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("a in_ready", 64'(a_ready), exp_ready(0));
      check("a out_valid", 64'(a_ovalid), 64'(mv[0]));
      check("a out_data", 64'(a_odata), 64'(md[0]));
      check("a out_source", 64'(a_osrc), 64'(ms[0]));
      check("b in_ready", 64'(b_ready), exp_ready(1));
      check("b out_valid", 64'(b_ovalid), 64'(mv[1]));
      check("b out_data", 64'(b_odata), 64'(md[1][7:0]));
      check("b out_source", 64'(b_osrc), 64'(ms[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_data = '0; a_valid = '0; a_mode = 1'b0; a_sel = '0; a_oready = 1'b0;
    b_data = '0; b_valid = '0; b_mode = 1'b0; b_sel = '0; b_oready = 1'b0;
    a_valid = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(a_ready), 64'h0);
    check("reset out_valid", 64'(a_ovalid), 64'h0);
    check("reset out_data", 64'(a_odata), 64'h0);
    check("reset out_source", 64'(a_osrc), 64'h0);
    a_valid = '0;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // fixed select, channel 5
    a_sel = 4'd5; a_valid = 16'h0020; a_data[5*32 +: 32] = 32'hDEAD_BEEF; a_oready = 1'b1;
    #1 check("t1 in_ready", 64'(a_ready), 64'h0020);
    step();
    check("t1 out_valid", 64'(a_ovalid), 64'h1);
    check("t1 out_data", 64'(a_odata), 64'hDEAD_BEEF);
    check("t1 out_source", 64'(a_osrc), 64'h5);

    // select an idle channel: word drains, nothing reloads
    a_sel = 4'd3; a_valid = '0;
    step();
    check("t2 out_valid", 64'(a_ovalid), 64'h0);
    check("t2 out_data held", 64'(a_odata), 64'hDEAD_BEEF);
    check("t2 out_source held", 64'(a_osrc), 64'h5);

    // out-of-range select on the 5-input instance
    b_sel = 3'd6; b_valid = 5'h1F; b_oready = 1'b1; b_data = 40'h55_44_33_22_11;
    #1 check("t2 bad sel in_ready", 64'(b_ready), 64'h0);
    step();
    check("t2 bad sel out_valid", 64'(b_ovalid), 64'h0);
    b_sel = 3'd4;
    #1 check("t2 sel4 in_ready", 64'(b_ready), 64'h10);
    step();
    check("t2 sel4 out_source", 64'(b_osrc), 64'h4);
    check("t2 sel4 out_data", 64'(b_odata), 64'h55);
    b_valid = '0;

    // round robin, all requesting
    a_mode = 1'b1; a_valid = 16'hFFFF;
    for (int i = 0; i < 16; i++) a_data[i*32 +: 32] = 32'h100 + i;
    for (int k = 0; k <= 16; k++) begin
      step();
      check("t3 rr out_source", 64'(a_osrc), 64'(k % 16));
      check("t3 rr out_data", 64'(a_odata), 64'(32'h100 + (k % 16)));
    end

    // round robin, channels 0 and 15
    a_valid = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t4 onehot", 64'($onehot(a_ready)), 64'h1);
      check("t4 in_ready", 64'(a_ready), (k % 2 == 0) ? 64'h8000 : 64'h0001);
      step();
      check("t4 out_source", 64'(a_osrc), (k % 2 == 0) ? 64'd15 : 64'd0);
    end

    // back-pressure
    a_mode = 1'b0; a_sel = 4'd2; a_valid = 16'h0004; a_data[2*32 +: 32] = 32'hAAAA_0001;
    step();
    check("t5 load A", 64'(a_odata), 64'hAAAA_0001);
    a_oready = 1'b0; a_data[2*32 +: 32] = 32'hBBBB_0002;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5 stall data", 64'(a_odata), 64'hAAAA_0001);
      check("t5 stall valid", 64'(a_ovalid), 64'h1);
      check("t5 stall in_ready", 64'(a_ready), 64'h0);
    end
    a_oready = 1'b1;
    #1 check("t5 release in_ready", 64'(a_ready), 64'h0004);
    step();
    check("t5 load B", 64'(a_odata), 64'hBBBB_0002);
    check("t5 B valid", 64'(a_ovalid), 64'h1);

    // async reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check("t6 reset out_valid", 64'(a_ovalid), 64'h0);
    check("t6 reset in_ready", 64'(a_ready), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    a_mode = 1'b1; a_valid = 16'h0011;
    #1 check("t6 first grant", 64'(a_ready), 64'h0001);
    step();
    check("t6 out_source 0", 64'(a_osrc), 64'h0);
    step();
    check("t6 out_source 4", 64'(a_osrc), 64'h4);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      a_valid = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      b_valid = 5'($urandom);
      for (int i = 0; i < 16; i++) a_data[i*32 +: 32] = $urandom;
      b_data = {8'($urandom), 32'($urandom)};
      a_oready = ($urandom_range(0, 3) != 0);
      b_oready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 15) == 0) b_mode = ~b_mode;
      a_sel = 4'($urandom_range(0, 15));
      b_sel = 3'($urandom_range(0, 7));
      step();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
